p66b_blocklock: RTL and testbench
=================================

// Module: p66b_blocklock
// PURPOSE
//  Block-lock and BER controller for the 64b/66b RX path (IEEE 802.3 cl.49).
//  Watches the 2-bit sync header of each 66b block leaving the RX gearbox.
//  Issues one-bit slip requests to the gearbox until alignment is found.
//  Reports block lock and high-BER status to the PCS/MAC.
// PARAMETERS
//  LOCK_CNT     64     consecutive valid headers needed to declare lock; window size once locked
//  INVALID_MAX  16     invalid headers within one LOCK_CNT window that drop lock
//  SLIP_WAIT    4      i_valid blocks ignored after each slip (gearbox settle)
//  BER_BLOCKS   19531  BER window length in i_valid blocks (~125us at 156.25M blk/s)
//  BER_LIMIT    16     invalid headers in one BER window that assert o_hi_ber
// PORTS
//  i_clk         in   1  clock
//  i_reset       in   1  synchronous, active-high reset
//  i_valid       in   1  one 66b block presented this cycle
//  i_sync        in   2  sync header bits [1:0] of that block
//  o_slip        out  1  one-cycle pulse: gearbox shifts alignment by one bit
//  o_block_lock  out  1  header alignment locked
//  o_hi_ber      out  1  high bit-error-rate flag
//  o_ber_count   out  8  invalid headers in current BER window, saturating at 255
// BEHAVIOUR
//  - Reset: all outputs 0, all counters 0, FSM state = TEST. Reset asserted
//    mid-operation aborts any pending slip wait and drops lock next cycle.
//  - sh_valid = i_sync[1] ^ i_sync[0]. State advances only on cycles with i_valid.
//  - All outputs are registered: a decision on the i_valid of cycle N is
//    visible on cycle N+1.
//  - FSM states:
//    TEST   unlocked. Valid header: sh_cnt+1. When sh_cnt reaches LOCK_CNT,
//           o_block_lock<=1, clear counters, go LOCKED.
//           Invalid header: o_slip pulses, sh_cnt<=0, go WAIT.
//    WAIT   drop SLIP_WAIT i_valid blocks without testing, then go TEST.
//           o_slip stays 0 in this state.
//    LOCKED each valid block: sh_cnt+1; invalid header: inv_cnt+1.
//           If inv_cnt reaches INVALID_MAX, o_block_lock<=0, o_slip pulses,
//           counters clear, go WAIT. This takes priority over window end.
//           Else if sh_cnt reaches LOCK_CNT (window end), clear both
//           counters and stay LOCKED. The window's last block is counted.
//  - o_slip is never asserted on two consecutive cycles. At most one pulse per
//    slip decision.
//  - BER monitor runs only while o_block_lock=1. When unlocked, o_hi_ber,
//    ber_cnt and the window timer are held at 0.
//    * Window timer counts i_valid blocks 1..BER_BLOCKS, then restarts.
//    * Each invalid header: ber_cnt+1 (saturates at 255).
//    * When ber_cnt reaches BER_LIMIT, o_hi_ber<=1 on the next cycle.
//    * At window end: o_hi_ber <= (final count >= BER_LIMIT), and ber_cnt<=0.
//      The final count includes the block that ends the window.
//    * o_ber_count = ber_cnt.
//  - Cycles without i_valid change nothing; i_sync is ignored on those cycles.
//  - Counter widths come from $clog2 of the parameters, plus 1 bit of margin.
//    No counter ever wraps.
// TESTING
//  1 Reset, then 64 blocks with i_sync=2'b01 -> o_block_lock=1 the cycle after
//    the 64th i_valid; o_slip never pulses.
//  2 Unlocked, block with i_sync=2'b11 -> o_slip=1 for exactly one cycle.
//    The next 4 blocks are ignored (even if invalid), then testing resumes.
//  3 Locked, 16 invalid headers within one 64-block window -> lock drops and
//    o_slip pulses after the 16th. 15 invalid per window -> stays locked.
//  4 Locked, BER_BLOCKS=100 and 16 invalid headers spread across 70 blocks ->
//    o_hi_ber=1 the cycle after the 16th. A following clean window ->
//    o_hi_ber=0 at its end.
//  5 Reset asserted while in WAIT and while LOCKED -> all outputs 0 next cycle.
//    A lock then reacquires in 64 clean blocks.
//  6 Closed loop with a gearbox model starting at a random bit offset ->
//    lock within 66 slips; o_hi_ber=0 on clean data.

Source files
------------

// File: rtl/p66b_blocklock_if.sv
// p66b_blocklock_if
//   Groups the per-block header stream and the lock/BER status of the
//   64b/66b block-lock controller.
//   i_valid      gearbox -> controller  one 66b block presented this cycle
//   i_sync       gearbox -> controller  sync header bits [1:0] of that block
//   o_slip       controller -> gearbox  one-cycle pulse: shift alignment by one bit
//   o_block_lock controller -> PCS      header alignment locked
//   o_hi_ber     controller -> PCS      high bit-error-rate flag
//   o_ber_count  controller -> PCS      invalid headers in current BER window
//   Modports: slave = controller side, master = gearbox/PCS side.
interface p66b_blocklock_if;
  logic       i_valid;
  logic [1:0] i_sync;
  logic       o_slip;
  logic       o_block_lock;
  logic       o_hi_ber;
  logic [7:0] o_ber_count;

  modport slave (
    input  i_valid, i_sync,
    output o_slip, o_block_lock, o_hi_ber, o_ber_count
  );

  modport master (
    output i_valid, i_sync,
    input  o_slip, o_block_lock, o_hi_ber, o_ber_count
  );
endinterface

// File: rtl/p66b_blocklock.sv
// p66b_blocklock
//   Block-lock and BER controller for the 64b/66b RX path. Watches the sync
//   header of each block leaving the RX gearbox, requests one-bit slips until
//   the headers line up, then reports block lock and high-BER status.
//   Ports:
//     i_clk    clock
//     i_reset  synchronous, active-high reset
//     bus      p66b_blocklock_if.slave (header stream in, slip/status out)
//   All outputs are registered: a decision taken on the i_valid block of
//   cycle N appears on cycle N+1.
module p66b_blocklock #(
  parameter int LOCK_CNT    = 64,
  parameter int INVALID_MAX = 16,
  parameter int SLIP_WAIT   = 4,
  parameter int BER_BLOCKS  = 19531,
  parameter int BER_LIMIT   = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  p66b_blocklock_if.slave    bus
);

  localparam int SH_W   = $clog2(LOCK_CNT) + 1;
  localparam int INV_W  = $clog2(INVALID_MAX) + 1;
  localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;
  localparam int TMR_W  = $clog2(BER_BLOCKS) + 1;
  localparam int BER_W  = 8;

  localparam logic [SH_W-1:0]   LOCK_CNT_V    = SH_W'(LOCK_CNT);
  localparam logic [INV_W-1:0]  INVALID_MAX_V = INV_W'(INVALID_MAX);
  localparam logic [WAIT_W-1:0] SLIP_WAIT_V   = WAIT_W'(SLIP_WAIT);
  localparam logic [TMR_W-1:0]  BER_BLOCKS_V  = TMR_W'(BER_BLOCKS);
  localparam logic [BER_W-1:0]  BER_LIMIT_V   = BER_W'(BER_LIMIT);
  localparam logic [BER_W-1:0]  BER_SAT       = '1;

  typedef enum logic [1:0] {
    ST_TEST   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t              state_reg,    state_next;
  logic [SH_W-1:0]     sh_cnt_reg,   sh_cnt_next;
  logic [INV_W-1:0]    inv_cnt_reg,  inv_cnt_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [TMR_W-1:0]    tmr_reg,      tmr_next;
  logic [BER_W-1:0]    ber_cnt_reg,  ber_cnt_next;
  logic                slip_reg,     slip_next;
  logic                lock_reg,     lock_next;
  logic                hi_ber_reg,   hi_ber_next;

  logic                sh_valid;
  logic [SH_W-1:0]     sh_inc;
  logic [INV_W-1:0]    inv_inc;
  logic [WAIT_W-1:0]   wait_inc;
  logic [TMR_W-1:0]    tmr_inc;
  logic [BER_W-1:0]    ber_inc;

  // A legal header is 01 or 10.
  assign sh_valid = bus.i_sync[1] ^ bus.i_sync[0];
  assign sh_inc   = sh_cnt_reg + 1'b1;
  assign inv_inc  = inv_cnt_reg + {{(INV_W-1){1'b0}}, ~sh_valid};
  assign wait_inc = wait_cnt_reg + 1'b1;
  assign tmr_inc  = tmr_reg + 1'b1;
  assign ber_inc  = (!sh_valid && ber_cnt_reg != BER_SAT) ? ber_cnt_reg + 1'b1 : ber_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= ST_TEST;
      sh_cnt_reg   <= '0;
      inv_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      tmr_reg      <= '0;
      ber_cnt_reg  <= '0;
      slip_reg     <= 1'b0;
      lock_reg     <= 1'b0;
      hi_ber_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sh_cnt_reg   <= sh_cnt_next;
      inv_cnt_reg  <= inv_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      tmr_reg      <= tmr_next;
      ber_cnt_reg  <= ber_cnt_next;
      slip_reg     <= slip_next;
      lock_reg     <= lock_next;
      hi_ber_reg   <= hi_ber_next;
    end
  end

  // Lock FSM. o_slip is a pulse: it defaults low and is only raised on the
  // transition into WAIT, and WAIT lasts at least one block, so two slip
  // pulses can never be adjacent.
  always_comb begin
    state_next    = state_reg;
    sh_cnt_next   = sh_cnt_reg;
    inv_cnt_next  = inv_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    lock_next     = lock_reg;
    slip_next     = 1'b0;

    if (bus.i_valid) begin
      case (state_reg)
        ST_TEST: begin
          if (sh_valid) begin
            if (sh_inc == LOCK_CNT_V) begin
              lock_next    = 1'b1;
              sh_cnt_next  = '0;
              inv_cnt_next = '0;
              state_next   = ST_LOCKED;
            end else begin
              sh_cnt_next = sh_inc;
            end
          end else begin
            slip_next     = 1'b1;
            sh_cnt_next   = '0;
            wait_cnt_next = '0;
            state_next    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Blocks arriving while the gearbox settles are not tested.
          if (wait_inc == SLIP_WAIT_V) begin
            wait_cnt_next = '0;
            state_next    = ST_TEST;
          end else begin
            wait_cnt_next = wait_inc;
          end
        end
        ST_LOCKED: begin
          // Too many bad headers wins over the window boundary.
          if (inv_inc == INVALID_MAX_V) begin
            lock_next     = 1'b0;
            slip_next     = 1'b1;
            sh_cnt_next   = '0;
            inv_cnt_next  = '0;
            wait_cnt_next = '0;
            state_next    = ST_WAIT;
          end else if (sh_inc == LOCK_CNT_V) begin
            sh_cnt_next  = '0;
            inv_cnt_next = '0;
          end else begin
            sh_cnt_next  = sh_inc;
            inv_cnt_next = inv_inc;
          end
        end
        default: begin
          state_next = ST_TEST;
        end
      endcase
    end
  end

  // BER monitor. It is keyed off lock_next so the counters are already zero
  // on the same cycle that o_block_lock falls, and only counts blocks that
  // arrive while lock is already established.
  always_comb begin
    tmr_next     = tmr_reg;
    ber_cnt_next = ber_cnt_reg;
    hi_ber_next  = hi_ber_reg;

    if (!lock_next) begin
      tmr_next     = '0;
      ber_cnt_next = '0;
      hi_ber_next  = 1'b0;
    end else if (bus.i_valid && lock_reg) begin
      if (tmr_inc == BER_BLOCKS_V) begin
        // The block closing the window is part of the window's verdict.
        hi_ber_next  = (ber_inc >= BER_LIMIT_V);
        ber_cnt_next = '0;
        tmr_next     = '0;
      end else begin
        tmr_next     = tmr_inc;
        ber_cnt_next = ber_inc;
        if (ber_inc >= BER_LIMIT_V) begin
          hi_ber_next = 1'b1;
        end
      end
    end
  end

  assign bus.o_slip       = slip_reg;
  assign bus.o_block_lock = lock_reg;
  assign bus.o_hi_ber     = hi_ber_reg;
  assign bus.o_ber_count  = ber_cnt_reg;

endmodule

// File: tb/tb_p66b_blocklock.sv
// tb_p66b_blocklock
//   Self-checking bench for p66b_blocklock (BER window shortened to 100
//   blocks). Each driven block pushes its expected outputs onto a scoreboard
//   queue; the entry is popped and compared one clock later when the
//   registered outputs appear.
module tb_p66b_blocklock;

  logic clk;
  logic rst;

  p66b_blocklock_if bus ();

  p66b_blocklock #(
    .LOCK_CNT    (64),
    .INVALID_MAX (16),
    .SLIP_WAIT   (4),
    .BER_BLOCKS  (100),
    .BER_LIMIT   (16)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       slip;
    logic       lock;
    logic       hi;
    logic [7:0] ber;
  } exp_t;

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic       slip;
    logic       lock;
  } vec_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic sb_check();
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got no expectation, required one");
    end else begin
      e = sb_q.pop_front();
      if (bus.o_slip !== e.slip || bus.o_block_lock !== e.lock ||
          bus.o_hi_ber !== e.hi || bus.o_ber_count !== e.ber) begin
        failures++;
        $display("FAIL %s: got slip=%b lock=%b hi_ber=%b ber=%0d, required slip=%b lock=%b hi_ber=%b ber=%0d",
                 e.name, bus.o_slip, bus.o_block_lock, bus.o_hi_ber, bus.o_ber_count,
                 e.slip, e.lock, e.hi, e.ber);
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Drive one cycle, push its expectation, compare after the edge.
  task automatic blk(input logic v, input logic [1:0] s, input string name,
                     input logic e_slip, input logic e_lock, input logic e_hi,
                     input logic [7:0] e_ber);
    exp_t e;
    bus.i_valid = v;
    bus.i_sync  = s;
    e.name = name; e.slip = e_slip; e.lock = e_lock; e.hi = e_hi; e.ber = e_ber;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    sb_check();
    $display("blk %s v=%b sync=%b -> slip=%b lock=%b hi_ber=%b ber=%0d",
             name, v, s, bus.o_slip, bus.o_block_lock, bus.o_hi_ber, bus.o_ber_count);
  endtask

  // Reset cycle with a bad header presented: reset must dominate.
  task automatic rst_blk(input string name);
    rst = 1'b1;
    blk(1'b1, 2'b11, name, 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
  endtask

  task automatic acquire(input string tag);
    for (int i = 1; i <= 64; i++)
      blk(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, $sformatf("%s_clean%0d", tag, i),
          1'b0, (i == 64), 1'b0, 8'd0);
  endtask

  vec_t tbl[10];
  int   off;
  int   slips;
  int   cyc;
  int   nbad;

  initial begin
    // Slip / settle sequence from reset (TEST state).
    tbl[0] = '{v: 1'b1, s: 2'b01, slip: 1'b0, lock: 1'b0};
    tbl[1] = '{v: 1'b1, s: 2'b11, slip: 1'b1, lock: 1'b0};
    tbl[2] = '{v: 1'b1, s: 2'b11, slip: 1'b0, lock: 1'b0};
    tbl[3] = '{v: 1'b0, s: 2'b11, slip: 1'b0, lock: 1'b0};
    tbl[4] = '{v: 1'b1, s: 2'b00, slip: 1'b0, lock: 1'b0};
    tbl[5] = '{v: 1'b1, s: 2'b11, slip: 1'b0, lock: 1'b0};
    tbl[6] = '{v: 1'b1, s: 2'b11, slip: 1'b0, lock: 1'b0};
    tbl[7] = '{v: 1'b1, s: 2'b01, slip: 1'b0, lock: 1'b0};
    tbl[8] = '{v: 1'b1, s: 2'b00, slip: 1'b1, lock: 1'b0};
    tbl[9] = '{v: 1'b1, s: 2'b00, slip: 1'b0, lock: 1'b0};

    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sync  = 2'b00;
    @(posedge clk);
    #1;
    rst_blk("reset_state");

    for (int i = 0; i < 10; i++)
      blk(tbl[i].v, tbl[i].s, $sformatf("slip_tbl%0d", i), tbl[i].slip, tbl[i].lock, 1'b0, 8'd0);

    // Lock on 64 clean blocks.
    rst_blk("reset_before_lock");
    acquire("lock");

    // Idle cycles with a bad header change nothing.
    blk(1'b0, 2'b11, "idle_locked", 1'b0, 1'b1, 1'b0, 8'd0);

    // 16 invalid headers inside one lock window drop lock.
    for (int k = 1; k <= 16; k++)
      blk(1'b1, 2'b00, $sformatf("inv%0d", k), (k == 16), (k != 16), 1'b0,
          (k == 16) ? 8'd0 : 8'(k));
    blk(1'b1, 2'b11, "wait_a", 1'b0, 1'b0, 1'b0, 8'd0);
    blk(1'b1, 2'b01, "wait_b", 1'b0, 1'b0, 1'b0, 8'd0);

    // Reset in WAIT: pending settle aborted, lock in exactly 64 blocks.
    rst_blk("reset_in_wait");
    acquire("relock1");

    // BER: 15 bad in lock window 1, 16th at block 66 of the BER window.
    nbad = 0;
    for (int b = 1; b <= 200; b++) begin
      logic bad;
      bad = ((b % 4 == 0) && b <= 60) || (b == 66);
      if (bad) nbad++;
      blk(1'b1, bad ? 2'b11 : 2'b10, $sformatf("ber_b%0d", b), 1'b0, 1'b1,
          (b >= 66 && b < 200), (b < 100) ? 8'(nbad) : 8'd0);
    end

    // Reset while locked, then reacquire.
    rst_blk("reset_in_locked");
    acquire("relock2");

    // Closed loop against a gearbox model at a random bit offset.
    rst_blk("reset_loop");
    off   = $urandom_range(0, 65);
    slips = 0;
    cyc   = 0;
    $display("loop start offset=%0d", off);
    while (!bus.o_block_lock && cyc < 20000) begin
      bus.i_valid = 1'b1;
      if (off == 0) bus.i_sync = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
      else          bus.i_sync = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      if (bus.o_slip) begin
        off = (off + 1) % 66;
        slips++;
      end
      cyc++;
    end
    chk("loop_locked", int'(bus.o_block_lock), 1);
    chk("loop_offset", off, 0);
    chk("loop_slips_le_66", int'(slips <= 66), 1);
    $display("loop locked=%b slips=%0d cycles=%0d", bus.o_block_lock, slips, cyc);
    for (int i = 1; i <= 150; i++)
      blk(1'b1, ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10,
          $sformatf("loop_clean%0d", i), 1'b0, 1'b1, 1'b0, 8'd0);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
